// File: rtl/sram_access_ctrl_if.sv
// CPU-side request/response bundle for sram_access_ctrl.
// The byte-enable lane exists only when SRAM_BYTE_EN_EN is defined.
interface sram_access_ctrl_if;
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
`ifdef SRAM_BYTE_EN_EN
    logic [1:0]  be;
`endif
    logic [15:0] rdata;
    logic        done;
    logic        busy;

    modport master (
        output req, wr, addr, wdata,
`ifdef SRAM_BYTE_EN_EN
        output be,
`endif
        input  rdata, done, busy
    );

    modport slave (
        input  req, wr, addr, wdata,
`ifdef SRAM_BYTE_EN_EN
        input  be,
`endif
        output rdata, done, busy
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Single-word read/write sequencer for an external 1Mx16 async SRAM with programmable wait states.
// Optional feature macro: SRAM_BYTE_EN_EN adds per-byte enables (bus.be) driving UB/LB.
module sram_access_ctrl #(
    parameter int         WAIT_CYCLES = 2,
    parameter logic [3:0] ADDR_HI     = 4'h0
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_access_ctrl_if.slave bus,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic              UB,
    output logic              LB,
    output logic [19:0]       ADDR,
    inout  wire  [15:0]       Data
);

    localparam int unsigned WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int unsigned CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_q;
    logic [15:0]      wdata_q;
    logic [15:0]      rdata_q;
    logic [19:0]      addr_q;
    logic             ce_q, oe_q, we_q, ub_q, lb_q;
    logic             drive_q;
    logic             done_q;
    logic             busy_q;
    logic             ub_act_c, lb_act_c;

    // Lane strobe levels used for the whole transaction, taken from the request.
    always_comb begin
`ifdef SRAM_BYTE_EN_EN
        ub_act_c = ~bus.be[1];
        lb_act_c = ~bus.be[0];
`else
        ub_act_c = 1'b0;
        lb_act_c = 1'b0;
`endif
    end

    // Sequencer: strobes are registered alongside the state they belong to.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        wr_q    <= bus.wr;
                        wdata_q <= bus.wdata;
                        addr_q  <= {ADDR_HI, bus.addr};
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        ce_q    <= 1'b0;
                        ub_q    <= ub_act_c;
                        lb_q    <= lb_act_c;
                        if (bus.wr) begin
                            state_q <= SETUP;
                            drive_q <= 1'b1;
                        end else begin
                            state_q <= ACCESS;
                            oe_q    <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    we_q    <= 1'b0;
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (wr_q) begin
                            state_q <= HOLD;
                            we_q    <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            rdata_q <= Data;
                            ce_q    <= 1'b1;
                            oe_q    <= 1'b1;
                            ub_q    <= 1'b1;
                            lb_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    state_q <= DONE;
                    ce_q    <= 1'b1;
                    ub_q    <= 1'b1;
                    lb_q    <= 1'b1;
                    drive_q <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Data      = drive_q ? wdata_q : 16'bz;
    assign CE        = ce_q;
    assign OE        = oe_q;
    assign WE        = we_q;
    assign UB        = ub_q;
    assign LB        = lb_q;
    assign ADDR      = addr_q;
    assign bus.rdata = rdata_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule
